// File: rtl/dec16_seq.sv
// Multi-cycle 16-bit decrementer: subtracts one a 4-bit slice per cycle, stopping as soon
// as the borrow is absorbed. Operand and result each move through a valid/ready handshake.
module dec16_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             negative,
  output logic             borrow,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0]  LastIdx = IDXW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_work;
  logic [IDXW-1:0]   r_idx;
  logic              r_borrow;
  logic              r_ovf_cap;
  logic [WIDTH-1:0]  r_out;
  logic              r_zero, r_neg, r_borrow_o, r_ovf;

  logic [SLICE-1:0]  w_slice;
  logic [SLICE-1:0]  w_slice_new;
  logic              w_bout;
  logic              w_last;
  logic              w_finish;
  logic [WIDTH-1:0]  w_work_nxt;

  always_comb begin
    w_slice     = r_work[r_idx*SLICE +: SLICE];
    w_slice_new = w_slice - {{(SLICE-1){1'b0}}, r_borrow};
    w_bout      = (w_slice == '0) && r_borrow;
    w_last      = (r_idx == LastIdx);
    w_finish    = !w_bout || w_last;
    // Upper slices are left untouched, so they pass through unchanged.
    w_work_nxt  = r_work;
    w_work_nxt[r_idx*SLICE +: SLICE] = w_slice_new;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_nxt = StCalc;
      StCalc:  if (w_finish) w_state_nxt = StDone;
      StDone:  if (out_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_work     <= '0;
      r_idx      <= '0;
      r_borrow   <= 1'b0;
      r_ovf_cap  <= 1'b0;
      r_out      <= '0;
      r_zero     <= 1'b0;
      r_neg      <= 1'b0;
      r_borrow_o <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_work    <= inp;
            r_idx     <= '0;
            r_borrow  <= 1'b1;
            r_ovf_cap <= (inp == MinNeg);
          end
        end
        StCalc: begin
          r_work   <= w_work_nxt;
          r_borrow <= w_bout;
          if (w_finish) begin
            r_out      <= w_work_nxt;
            r_zero     <= (w_work_nxt == '0);
            r_neg      <= w_work_nxt[WIDTH-1];
            // Only a borrow leaving the top slice is an unsigned underflow.
            r_borrow_o <= w_bout && w_last;
            r_ovf      <= r_ovf_cap;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign out       = r_out;
  assign zero      = r_zero;
  assign negative  = r_neg;
  assign borrow    = r_borrow_o;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_dec16_seq.sv
// Self-checking bench for dec16_seq: scoreboard of expected results and latencies,
// checked when the DUT presents each result.
module tb_dec16_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] inp = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out;
  logic        zero, negative, borrow, overflow, busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        z, n, b, o;
    logic [2:0]  k;
  } exp_t;

  exp_t sb_q[$];

  dec16_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .negative  (negative),
    .borrow    (borrow),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] x);
    exp_t e;
    e.res = x - 16'd1;
    e.z   = (e.res == 16'h0);
    e.n   = e.res[15];
    e.b   = (x == 16'h0000);
    e.o   = (x == 16'h8000);
    e.k   = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (x[i*4 +: 4] != 4'h0) e.k = 3'(i + 1);
    end
    return e;
  endfunction

  // Starts and ends on a falling edge with the DUT idle.
  task automatic do_op(input logic [15:0] x, input int hold);
    exp_t e;
    int n;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_before_op in_ready=%b required 1", in_ready);
    end
    in_valid  = 1'b1;
    inp       = x;
    out_ready = (hold == 0);
    sb_q.push_back(model(x));
    @(negedge clk);
    in_valid = 1'b0;
    inp      = 16'($urandom);
    n = 0;
    while (out_valid !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    checks++;
    if (n >= 12) begin
      failures++;
      $display("FAIL timeout inp=%h no out_valid after %0d cycles", x, n);
      return;
    end
    checks++;
    if (n !== int'(e.k)) begin
      failures++;
      $display("FAIL latency inp=%h got %0d required %0d", x, n, e.k);
    end
    checks++;
    if (out !== e.res || zero !== e.z || negative !== e.n || borrow !== e.b
        || overflow !== e.o) begin
      failures++;
      $display("FAIL result inp=%h got out=%h z%b n%b b%b o%b required out=%h z%b n%b b%b o%b",
               x, out, zero, negative, borrow, overflow, e.res, e.z, e.n, e.b, e.o);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL done_status inp=%h in_ready=%b busy=%b required 0 1", x, in_ready, busy);
    end
    if (hold > 0) begin
      in_valid = 1'b1;
      inp      = 16'h1234;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checks++;
        if (out !== e.res || out_valid !== 1'b1 || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL hold cyc=%0d out=%h out_valid=%b in_ready=%b required %h 1 0",
                   i, out, out_valid, in_ready, e.res);
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out !== e.res) begin
      failures++;
      $display("FAIL after_ack inp=%h in_ready=%b out_valid=%b busy=%b out=%h required 1 0 0 %h",
               x, in_ready, out_valid, busy, out, e.res);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b busy=%b required 1 0 0",
               in_ready, out_valid, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 16'h0 || zero !== 1'b0
        || negative !== 1'b0 || borrow !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals in_ready=%b out_valid=%b out=%h flags=%b%b%b%b busy=%b",
               in_ready, out_valid, out, zero, negative, borrow, overflow, busy);
    end
  endtask

  task automatic test_basic();
    do_op(16'h000B, 0);
    do_op(16'h0000, 0);
    do_op(16'h8000, 0);
    do_op(16'h0001, 0);
    do_op(16'h0100, 0);
  endtask

  task automatic test_hold();
    do_op(16'h0010, 5);
  endtask

  task automatic test_reset_abort();
    in_valid = 1'b1;
    inp      = 16'h1000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out !== 16'h0
        || zero !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset out_valid=%b in_ready=%b busy=%b out=%h zero=%b required 0 1 0 0 0",
               out_valid, in_ready, busy, out, zero);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL abort_quiet cyc=%0d out_valid=%b in_ready=%b required 0 1",
                 i, out_valid, in_ready);
      end
    end
    do_op(16'h0002, 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] x;
    do_op(16'h7FF0, 0);
    do_op(16'hFFFF, 0);
    for (int i = 0; i < 8; i++) begin
      x = 16'($urandom);
      if (i[0]) x = x & 16'hF000;
      do_op(x, i % 3);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover size=%0d required 0", sb_q.size());
    end
  endtask

  // Handshake exclusivity must hold on every cycle.
  always @(negedge clk) begin
    if (rst && in_ready === 1'b1 && out_valid === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL exclusive in_ready and out_valid both high at %0t", $time);
    end
  end

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dec16_seq.md
# dec16_seq

Multi-cycle 16-bit decrement unit for the ALU arithmetic group, the down-counting counterpart of the registered incrementer. It accepts one operand through a valid/ready handshake and computes `inp - 1` one 4-bit slice per cycle, rippling the borrow. It stops as soon as the borrow is absorbed, so latency depends on the data. The result and status flags are presented through a second valid/ready handshake to the datapath write-back stage.

## Interface
- `WIDTH`, 16: operand width; fixed at 16 for this release.
- `SLICE`, 4: bits processed per cycle. `WIDTH % SLICE == 0` is required; `NSLICE = WIDTH/SLICE = 4`.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand on `inp` is valid.
- `in_ready` out 1: unit can accept an operand.
- `inp` in 16: operand, unsigned or two's complement.
- `out_valid` out 1: `out` and the flags hold a new result.
- `out_ready` in 1: consumer accepts the result.
- `out` out 16: `inp - 1` modulo 2^16.
- `zero` out 1: `out == 0`.
- `negative` out 1: `out[15]`.
- `borrow` out 1: unsigned underflow, i.e. `inp == 0x0000`.
- `overflow` out 1: signed overflow, i.e. `inp == 0x8000`.
- `busy` out 1: state is not IDLE.

## Operation
- There are three states: IDLE, CALC and DONE. At most one operation is in flight.
- IDLE:
  - `in_ready=1`.
  - On `in_valid && in_ready`: capture `inp` into the internal work register, set the internal borrow to 1 and the slice index to 0, then go to CALC.
- CALC, one slice per cycle:
  - `work[idx*4 +: 4] <= slice - borrow_in`.
  - `borrow_out = (slice == 0) && borrow_in`.
  - If `borrow_out == 0` or `idx == NSLICE-1`, go to DONE. Otherwise increment `idx` and stay in CALC.
  - Untouched upper slices pass through unchanged.
- Entering DONE registers the following, all from the final work value:
  - `out`
  - `zero`, `negative`
  - `borrow` = borrow out of the top slice
  - `overflow` = `(captured inp == 0x8000)`
- DONE:
  - `out_valid=1`.
  - On `out_ready`, go to IDLE.
  - `out` and the flags keep their values after the handshake, until the next entry to DONE.
- `in_valid`, `inp` and `out_ready` are ignored outside the states where they are sampled. Changes to `inp` during CALC or DONE have no effect.
- `out_ready` seen in IDLE or CALC has no effect; it never pre-acknowledges a result.
- Reset values: state IDLE; `out=0`, all flags 0; `out_valid=0`, `busy=0`; `in_ready=1`; work register, index and borrow cleared.
- Reset asserted mid-operation aborts it immediately (asynchronously). The partial result is discarded and no `out_valid` pulse is produced.

## Timing
- Let edge E0 be the accepting edge. Number of CALC cycles `k` = index of the lowest nonzero slice of `inp` + 1, with `k = 4` if `inp == 0`. Range is 1..4.
- State is CALC after edges E0..E(k-1) and DONE after edge Ek. `out_valid` is first high in the cycle following Ek.
- Examples of `k`:
  - `0x000B`: 1
  - `0x0010`: 2
  - `0x0100`: 3
  - `0x1000`, `0x8000`, `0x0000`: 4
- `in_ready` and `out_valid` are never high together. After the `out_ready` edge, `in_ready` is high in the next cycle.
- Minimum issue interval is k+2 cycles (accept, k CALC, at least one DONE).
- DONE with `out_ready` held high lasts exactly one cycle. With `out_ready` low, DONE and all outputs are held indefinitely.
- `busy` is 1 exactly when `in_ready` is 0.

## Test plan
- Reset released at cycle 1.5 with `in_valid=0`:
  - `in_ready=1`, `out_valid=0`, `out=0`, flags 0.
- `inp=0x000B`, `out_ready=1`:
  - `out_valid` appears 1 edge after acceptance.
  - `out=0x000C-2=0x000A`, all flags 0.
- `inp=0x0000`:
  - `k=4`, `out=0xFFFF`.
  - `borrow=1`, `negative=1`, `zero=0`, `overflow=0`.
- `inp=0x8000`:
  - `k=4`, `out=0x7FFF`.
  - `overflow=1`, `negative=0`, `borrow=0`.
- `inp=0x0001`:
  - `k=1`, `out=0x0000`, `zero=1`.
- `inp=0x0010` with `out_ready=0` for 5 cycles after `out_valid`:
  - `out=0x000F` held stable and `in_ready=0` throughout.
  - A new `in_valid` during that window is not accepted.
  - Raising `out_ready` gives IDLE on the next edge.
- `inp=0x1000`, reset asserted after 2 CALC edges:
  - Outputs go to reset values immediately and no `out_valid` follows.
  - A subsequent operation with `inp=0x0002` gives `out=0x0001`.
